// File: rtl/instr_wb_master.sv
// Wishbone B4 pipelined single-transfer master for instrumentation accesses.
// One transfer at a time: latch request, present strobe until accepted, wait for ack or timeout.
module instr_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        wb_cyc_o,
    input  logic        wb_stall_i,
    input  logic        request_i,
    input  logic [31:0] req_adr_i,
    input  logic [31:0] req_dat_i,
    input  logic        req_we_i,
    input  logic [3:0]  req_sel_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] read_data_o
);

    typedef enum logic [1:0] {IDLE, REQUEST, WAIT_ACK, DONE} state_e;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [31:0] adr_q, dat_q, rdata_q;
    logic [3:0]  sel_q;
    logic        we_q, stb_q, cyc_q, busy_q, done_q, err_q;

    logic        timeout;
    logic        ack_ok;

    assign timeout = (cnt_q == TO_LAST);
    // An ack only counts once the strobe has been accepted (stall low) or afterwards.
    assign ack_ok  = wb_ack_i && ((state_q == WAIT_ACK) || (state_q == REQUEST && !wb_stall_i));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            stb_q   <= 1'b0;
            cyc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (request_i) begin
                        adr_q   <= req_adr_i;
                        dat_q   <= req_dat_i;
                        we_q    <= req_we_i;
                        sel_q   <= req_sel_i;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= REQUEST;
                    end
                end
                REQUEST, WAIT_ACK: begin
                    // Ack beats a simultaneous timeout.
                    if (ack_ok) begin
                        if (!we_q) rdata_q <= wb_dat_i;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                        state_q <= DONE;
                    end else if (timeout) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (state_q == REQUEST && !wb_stall_i) begin
                            stb_q   <= 1'b0;
                            state_q <= WAIT_ACK;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_we_o     = we_q;
    assign wb_sel_o    = sel_q;
    assign wb_stb_o    = stb_q;
    assign wb_cyc_o    = cyc_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = err_q;
    assign read_data_o = rdata_q;

endmodule
